// File: rtl/spmv_pkg.sv
// Shared AXI constants and arbiter state type for the SpMV HBM read path.
package spmv_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/hbm_val_rd_arbiter_chk.sv
// Simulation-only protocol checks for the HBM Val read arbiter.
module hbm_val_rd_arbiter_chk #(
    parameter int unsigned ADDR_W = 48
) (
    input logic              clk_i,
    input logic              rst_ni,
    input logic              arvalid_i,
    input logic              arready_i,
    input logic [ADDR_W-1:0] araddr_i,
    input logic [7:0]        arlen_i,
    input logic [2:0]        arsize_i,
    input logic [1:0]        arburst_i,
    input logic              rvalid_i,
    input logic              empty_i
);

    a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (arvalid_i && !arready_i) |=>
            (arvalid_i && $stable({araddr_i, arlen_i, arsize_i, arburst_i})))
        else $error("AR fields changed while arvalid was pending");

    a_r_orphan: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid_i && empty_i))
        else $error("R beat arrived with no burst outstanding");

endmodule

// File: rtl/rr_fifo.sv
// Synchronous FIFO of requester indices; DEPTH must be a power of two, at least 2.
module rr_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hbm_val_rd_arbiter.sv
// Round-robin arbiter sharing the HBM Val AXI4 read port among SpMV kernels;
// R bursts are routed back in issue order through a FIFO of requester indices.
module hbm_val_rd_arbiter
    import spmv_pkg::*;
#(
    parameter int unsigned CONF_NUM_KERNEL = 1,
    parameter int unsigned ADDR_W          = 48,
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                axis_clk,
    input  logic                                rstn,
    input  logic [CONF_NUM_KERNEL*ADDR_W-1:0]   s_araddr,
    input  logic [CONF_NUM_KERNEL*8-1:0]        s_arlen,
    input  logic [CONF_NUM_KERNEL*3-1:0]        s_arsize,
    input  logic [CONF_NUM_KERNEL*2-1:0]        s_arburst,
    input  logic [CONF_NUM_KERNEL-1:0]          s_arvalid,
    output logic [CONF_NUM_KERNEL-1:0]          s_arready,
    output logic [CONF_NUM_KERNEL*DATA_W-1:0]   s_rdata,
    output logic [CONF_NUM_KERNEL*2-1:0]        s_rresp,
    output logic [CONF_NUM_KERNEL-1:0]          s_rlast,
    output logic [CONF_NUM_KERNEL-1:0]          s_rvalid,
    input  logic [CONF_NUM_KERNEL-1:0]          s_rready,
    output logic [ADDR_W-1:0]                   m_axi_araddr,
    output logic [7:0]                          m_axi_arlen,
    output logic [2:0]                          m_axi_arsize,
    output logic [1:0]                          m_axi_arburst,
    output logic                                m_axi_arvalid,
    input  logic                                m_axi_arready,
    input  logic [DATA_W-1:0]                   m_axi_rdata,
    input  logic [1:0]                          m_axi_rresp,
    input  logic                                m_axi_rlast,
    input  logic                                m_axi_rvalid,
    output logic                                m_axi_rready,
    output logic                                m_axi_awvalid,
    output logic                                m_axi_wvalid,
    output logic                                m_axi_bready,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                rresp_err
);

    localparam int unsigned N  = CONF_NUM_KERNEL;
    localparam int unsigned IW = idx_width(CONF_NUM_KERNEL);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]          ar_len_q, ar_len_d;
    logic [2:0]          ar_size_q, ar_size_d;
    logic [1:0]          ar_burst_q, ar_burst_d;
    logic                rresp_err_q, rresp_err_d;

    logic                grant_found_s;
    logic [IW-1:0]       grant_idx_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [IW-1:0]       head_idx_s;
    logic                r_hs_s;

    assign m_axi_awvalid = 1'b0;
    assign m_axi_wvalid  = 1'b0;
    assign m_axi_bready  = 1'b1;

    assign m_axi_arvalid = (state_q == ISSUE);
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = ar_size_q;
    assign m_axi_arburst = ar_burst_q;
    assign rresp_err     = rresp_err_q;

    assign s_rdata = {N{m_axi_rdata}};
    assign s_rresp = {N{m_axi_rresp}};

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= int'(N)) begin
                cand = cand - int'(N);
            end else begin
                cand = cand;
            end
            if (!grant_found_s && s_arvalid[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IW'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // AR FSM: accept one request in IDLE, hold it on the master port in ISSUE.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        s_arready   = '0;
        fifo_push_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found_s && !fifo_full_s) begin
                    s_arready  = N'(1) << grant_idx_s;
                    ar_addr_d  = s_araddr[grant_idx_s*ADDR_W +: ADDR_W];
                    ar_len_d   = s_arlen[grant_idx_s*8 +: 8];
                    ar_size_d  = s_arsize[grant_idx_s*3 +: 3];
                    ar_burst_d = s_arburst[grant_idx_s*2 +: 2];
                    gidx_d     = grant_idx_s;
                    state_d    = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (m_axi_arready) begin
                    fifo_push_s = 1'b1;
                    rr_ptr_d    = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
                    state_d     = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // R routing: only the requester owning the oldest burst sees the channel.
    always_comb begin
        m_axi_rready = 1'b0;
        s_rvalid     = '0;
        s_rlast      = '0;
        if (!fifo_empty_s) begin
            m_axi_rready         = s_rready[head_idx_s];
            s_rvalid[head_idx_s] = m_axi_rvalid;
            s_rlast[head_idx_s]  = m_axi_rlast;
        end else begin
            m_axi_rready = 1'b0;
        end
    end

    assign r_hs_s      = m_axi_rvalid && m_axi_rready;
    assign fifo_pop_s  = r_hs_s && m_axi_rlast;
    assign rresp_err_d = rresp_err_q || (r_hs_s && (m_axi_rresp != RESP_OKAY));

    // Arbiter state and captured AR fields.
    always_ff @(posedge axis_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= 8'd0;
            ar_size_q   <= 3'd0;
            ar_burst_q  <= 2'd0;
            rresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            ar_burst_q  <= ar_burst_d;
            rresp_err_q <= rresp_err_d;
        end
    end

    rr_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i       (axis_clk),
        .rst_ni      (rstn),
        .push_i      (fifo_push_s),
        .push_data_i (gidx_q),
        .pop_i       (fifo_pop_s),
        .head_o      (head_idx_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (outstanding)
    );

    hbm_val_rd_arbiter_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk_i     (axis_clk),
        .rst_ni    (rstn),
        .arvalid_i (m_axi_arvalid),
        .arready_i (m_axi_arready),
        .araddr_i  (m_axi_araddr),
        .arlen_i   (m_axi_arlen),
        .arsize_i  (m_axi_arsize),
        .arburst_i (m_axi_arburst),
        .rvalid_i  (m_axi_rvalid),
        .empty_i   (fifo_empty_s)
    );

endmodule
